selevy_gout_capture: RTL
========================

// Module: selevy_gout_capture
// PURPOSE
//   Reader end of the selevy GPIO output port. Receives the core's gout
//   bus and out_clk strobe, synchronises them into the CLK domain and
//   captures gout on every out_clk rising edge into a small FIFO.
//   A host (bench or debug logic) drains the FIFO over a valid/ready port.
//   Turns the core's fire-and-forget GPIO writes into a lossless, ordered
//   stream with explicit overflow reporting.
// PARAMETERS
//   DATA_W       4  width of gout / rd_data
//   DEPTH        8  FIFO entries; power of two, >= 2
//   SYNC_STAGES  2  synchroniser flops on gout and out_clk; >= 2
// PORTS
//   CLK       in   1                    capture/read clock, rising edge
//   reset     in   1                    async, active-high; clears all state
//   gout      in   DATA_W               GPIO value from selevy core
//   out_clk   in   1                    GPIO strobe; capture on rising edge
//   rd_valid  out  1                    FIFO non-empty, rd_data valid
//   rd_data   out  DATA_W               head entry (first-word fall-through)
//   rd_ready  in   1                    host accepts head this cycle
//   count     out  $clog2(DEPTH)+1      entries held, 0..DEPTH
//   overflow  out  1                    sticky: a capture was dropped
//   ovf_clr   in   1                    clears overflow
// BEHAVIOUR
//   - Reset (async assert, sync release): FIFO empty, pointers 0, count=0,
//     rd_valid=0, rd_data=0, overflow=0, sync flops 0, edge detector disarmed.
//   - gout and out_clk pass through identical SYNC_STAGES-deep chains so data
//     and strobe stay aligned. gout must be stable from SYNC_STAGES+1 CLK
//     cycles before to SYNC_STAGES+1 after the out_clk rising edge.
//   - Edge detect: push strobe = synced out_clk 1 AND previous synced value 0
//     AND armed. Armed is set the first cycle the synced out_clk reads 0
//     after reset; an out_clk held high across reset release is not captured.
//   - Latency: out_clk first sampled high at CLK edge N -> entry written at
//     edge N+SYNC_STAGES; rd_valid/count update at that edge. No empty-bypass.
//   - Read: rd_data = head while rd_valid=1, else 0. Pop when
//     rd_valid && rd_ready; rd_ready while empty is ignored.
//   - Pointers DATA index modulo DEPTH, wrap silently; count = writes - reads.
//   - Push, not full: write, count+1. Push and pop same cycle: both occur,
//     count unchanged (also when full: no drop, no overflow).
//   - Push while full without pop: sample dropped, FIFO untouched,
//     overflow <= 1. overflow stays 1 until ovf_clr; set wins over ovf_clr
//     in the same cycle.
//   - Pop while empty: no effect. Count never exceeds DEPTH or goes below 0.
//   - Reset mid-operation: contents discarded immediately (async); any edge
//     in the synchroniser is lost.
// CONFIGURATION
//   GOUT_CAP_DEDUP_EN defined: a push is accepted only if synced gout differs
//     from the last successfully written value (register, reset 0, updated
//     only on a real write); equal values are silently skipped, never count
//     as overflow. First capture after reset with gout=0 is skipped.
//   Undefined: every qualified out_clk rising edge pushes, repeats included.
// TESTING
//   1 Reset; 3 out_clk pulses with gout=1,2,3; rd_ready=0 -> count=3,
//     rd_valid=1, rd_data=1; then rd_ready=1 -> reads 1,2,3, count=0, rd_valid=0.
//   2 rd_ready=0; 8 pulses gout=0..7 then gout=F -> count=8, overflow=1;
//     drain -> 0..7, F absent; pulse ovf_clr -> overflow=0.
//   3 FIFO full (0..7), rd_ready=1 same cycle as push of gout=9 -> count=8,
//     overflow=0, drained order 1..7,9.
//   4 out_clk=1 across reset release -> count stays 0; out_clk 0 then 1 with
//     gout=A -> exactly one entry A, visible SYNC_STAGES cycles after sampling.
//   5 count=5, assert reset between CLK edges -> count=0, rd_valid=0,
//     overflow=0 immediately, before next CLK edge.
//   6 Pulses with gout=5,5,6: GOUT_CAP_DEDUP_EN -> entries 5,6 (count=2);
//     without macro -> 5,5,6 (count=3).

Source files
------------

// File: rtl/selevy_gout_capture.sv
// ============================================================================
// Module   : selevy_gout_capture
// Purpose  : Reader end of the selevy GPIO output port. Synchronises the
//            core's gout bus and out_clk strobe into the CLK domain. On every
//            qualified out_clk rising edge it captures gout into a FIFO.
//            The FIFO is drained over a first-word-fall-through valid/ready
//            port. A sticky flag reports captures dropped while the FIFO was
//            full.
// Options  : GOUT_CAP_DEDUP_EN - when defined, skip a capture whose value
//            equals the last value actually written into the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module selevy_gout_capture #(
  parameter int DATA_W      = 4,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        gout,
  input  logic                     out_clk,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
  localparam logic [CW-1:0] C_CNT_FULL = CW'(DEPTH);

  // Synchroniser chains; gout and out_clk use identical depth so they stay aligned
  logic [SYNC_STAGES-1:0] oclk_sync_q;
  logic [DATA_W-1:0]      gout_sync_q [SYNC_STAGES];
  // Marks when the chains hold real samples rather than reset zeros
  logic [SYNC_STAGES-1:0] fill_q;

  logic              oclk_s_w;
  logic [DATA_W-1:0] gout_s_w;
  logic              sync_ok_w;

  // Edge detector state
  logic prev_q, prev_d;
  logic armed_q, armed_d;
  logic edge_w;
  logic push_req_w;

  // FIFO state
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;

  logic full_w;
  logic pop_w;
  logic wr_en_w;
  logic drop_w;

  // Shift out_clk, gout and the fill marker through the synchroniser stages
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      oclk_sync_q <= '0;
      fill_q      <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        gout_sync_q[i] <= '0;
      end
    end else begin
      oclk_sync_q    <= {oclk_sync_q[SYNC_STAGES-2:0], out_clk};
      fill_q         <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      gout_sync_q[0] <= gout;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        gout_sync_q[i] <= gout_sync_q[i-1];
      end
    end
  end

  assign oclk_s_w  = oclk_sync_q[SYNC_STAGES-1];
  assign gout_s_w  = gout_sync_q[SYNC_STAGES-1];
  assign sync_ok_w = fill_q[SYNC_STAGES-1];

  // Arm only after a genuine low has passed through the chain, so a strobe
  // held high across reset release never looks like a rising edge
  always_comb begin
    prev_d  = oclk_s_w;
    armed_d = armed_q | (sync_ok_w & ~oclk_s_w);
    edge_w  = sync_ok_w & oclk_s_w & ~prev_q & armed_q;
  end

  // Edge detector registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

`ifdef GOUT_CAP_DEDUP_EN
  logic [DATA_W-1:0] last_q;

  // Remember the last value that actually reached the FIFO
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      last_q <= '0;
    end else if (wr_en_w) begin
      last_q <= gout_s_w;
    end
  end

  assign push_req_w = edge_w & (gout_s_w != last_q);
`else
  assign push_req_w = edge_w;
`endif

  assign full_w   = (count_q == C_CNT_FULL);
  assign rd_valid = (count_q != '0);
  assign pop_w    = rd_valid & rd_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts it
  assign wr_en_w  = push_req_w & (~full_w | pop_w);
  assign drop_w   = push_req_w & full_w & ~pop_w;

  // Next pointer, occupancy and overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en_w) begin
      wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    end
    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end
    case ({wr_en_w, pop_w})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase
    if (drop_w) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // FIFO control registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; when full with a pop, the write lands in the slot being read
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_w) begin
      mem_q[wr_ptr_q] <= gout_s_w;
    end
  end

  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire
